// File: rtl/regfile_pkg.sv
// Shared types, default constants and byte-merge helper for the
// multiport register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 4;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_PC_IDX    = 15;
    localparam int DEF_PC_OFFSET = 8;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] i_old,
        input logic [7:0] i_new,
        input logic       i_be
    );
        return i_be ? i_new : i_old;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: array mux, same-cycle write/clear bypass,
// PC override and address range check.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int PC_EN     = 1,
    parameter int PC_IDX    = DEF_PC_IDX,
    parameter int PC_OFFSET = DEF_PC_OFFSET
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DEPTH*DATA_W-1:0] i_mem,
    input  logic [ADDR_W-1:0]       i_ra,
    input  logic                    i_wr_en,
    input  logic [ADDR_W-1:0]       i_wa,
    input  logic [DATA_W-1:0]       i_wd,
    input  logic [DATA_W/8-1:0]     i_wbe,
    input  logic                    i_clr_en,
    input  logic [ADDR_W-1:0]       i_clr_addr,
    input  logic [DATA_W-1:0]       i_pc,
    output logic [DATA_W-1:0]       o_rd
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_A    = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PC_OFF  = DATA_W'(PC_OFFSET);

    logic [DATA_W-1:0] w_cur;
    logic [DATA_W-1:0] w_byp;
    logic [DATA_W-1:0] w_nxt;
    logic              w_in_range;
    logic              w_pc_hit;

    assign w_in_range = {1'b0, i_ra} < DEPTH_L;
    assign w_pc_hit   = (PC_EN != 0) && (i_ra == PC_A);

    always_comb begin
        w_cur = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (i_ra == ADDR_W'(j)) begin
                w_cur = i_mem[j*DATA_W +: DATA_W];
            end
        end
    end

    // Clear and write never coincide: writes are dropped while busy.
    always_comb begin
        w_byp = w_cur;
        if (i_clr_en && (i_clr_addr == i_ra)) begin
            w_byp = '0;
        end else if (i_wr_en && (i_wa == i_ra)) begin
            for (int k = 0; k < DATA_W/8; k++) begin
                w_byp[8*k +: 8] = byte_merge(w_cur[8*k +: 8],
                                             i_wd[8*k +: 8],
                                             i_wbe[k]);
            end
        end
    end

    always_comb begin
        w_nxt = w_byp;
        if (w_pc_hit) begin
            w_nxt = i_pc + PC_OFF;
        end else if (!w_in_range) begin
            w_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rd <= '0;
        end else begin
            o_rd <= w_nxt;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register bank: byte-enabled write port, NUM_RD registered
// read ports with bypass, PC override and a sequenced clear.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_RD    = 2,
    parameter int PC_EN     = 1,
    parameter int PC_IDX    = DEF_PC_IDX,
    parameter int PC_OFFSET = DEF_PC_OFFSET
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_A    = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [DEPTH*DATA_W-1:0] w_mem_flat;
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_W-1:0]       r_cnt;
    logic [ADDR_W-1:0]       w_cnt_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic                    w_clr_en;
    logic                    w_wr_ok;

    assign busy    = r_busy;
    assign w_wr_ok = we && !r_busy
                  && ({1'b0, wa} < DEPTH_L)
                  && !((PC_EN != 0) && (wa == PC_A));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (clr_req)        w_state_nxt = CLEAR;
            CLEAR: if (r_cnt == LAST)  w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_clr_en   = (r_state == CLEAR);
        w_busy_nxt = (w_state_nxt == CLEAR);
        w_cnt_nxt  = w_clr_en ? r_cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                r_mem[i] <= '0;
            end else if (w_wr_ok && (wa == ADDR_W'(i))) begin
                for (int k = 0; k < DATA_W/8; k++) begin
                    r_mem[i][8*k +: 8] <= byte_merge(r_mem[i][8*k +: 8],
                                                     wd[8*k +: 8],
                                                     wbe[k]);
                end
            end else if (w_clr_en && (r_cnt == ADDR_W'(i))) begin
                r_mem[i] <= '0;
            end
        end
    end

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_flat
        assign w_mem_flat[g*DATA_W +: DATA_W] = r_mem[g];
    end

    for (g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rd_port #(
            .DATA_W    (DATA_W),
            .ADDR_W    (ADDR_W),
            .DEPTH     (DEPTH),
            .PC_EN     (PC_EN),
            .PC_IDX    (PC_IDX),
            .PC_OFFSET (PC_OFFSET)
        ) u_rd (
            .clk        (clk),
            .rst        (rst),
            .i_mem      (w_mem_flat),
            .i_ra       (ra[g*ADDR_W +: ADDR_W]),
            .i_wr_en    (w_wr_ok),
            .i_wa       (wa),
            .i_wd       (wd),
            .i_wbe      (wbe),
            .i_clr_en   (w_clr_en),
            .i_clr_addr (r_cnt),
            .i_pc       (pc_in),
            .o_rd       (rd[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with a behavioural model feeding
// an expectation queue that is drained one entry per clock.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst, we, clr_req;
    logic [3:0]  wa;
    logic [31:0] wd, pc_in;
    logic [3:0]  wbe;
    logic [3:0]  ra0, ra1;
    logic [63:0] rd;
    logic        busy;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_reg [16];
    logic        m_busy;
    logic [3:0]  m_cnt;
    int          n_pass = 0;
    int          n_total = 0;
    int          nb;

    always #5 clk = ~clk;

    regfile_multiport dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .wbe     (wbe),
        .ra      ({ra1, ra0}),
        .rd      (rd),
        .pc_in   (pc_in),
        .clr_req (clr_req),
        .busy    (busy)
    );

    function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                          logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] predict(logic [3:0] a);
        logic [31:0] v;
        if (rst) return 32'h0;
        if (a == 4'd15) return pc_in + 32'd8;
        v = m_reg[a];
        if (m_busy && a == m_cnt) v = 32'h0;
        else if (we && !m_busy && a == wa) v = merge(v, wd, wbe);
        return v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        exp_t e;
        e.d0 = predict(ra0);
        e.d1 = predict(ra1);
        if (rst) begin
            e.b = 1'b0;
            foreach (m_reg[i]) m_reg[i] = 32'h0;
            m_busy = 1'b0;
            m_cnt  = 4'd0;
        end else begin
            if (we && !m_busy && wa != 4'd15)
                m_reg[wa] = merge(m_reg[wa], wd, wbe);
            if (m_busy) begin
                m_reg[m_cnt] = 32'h0;
                if (m_cnt == 4'd15) m_busy = 1'b0;
                m_cnt = m_cnt + 4'd1;
            end else if (clr_req) begin
                m_busy = 1'b1;
                m_cnt  = 4'd0;
            end
            e.b = m_busy;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("rd0", rd[31:0], e.d0);
        chk("rd1", rd[63:32], e.d1);
        chk("busy", {31'b0, busy}, {31'b0, e.b});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; we = 0; clr_req = 0; wa = 0; wd = 0; wbe = 0;
        ra0 = 3; ra1 = 7; pc_in = 0;
        m_busy = 0; m_cnt = 0;
        foreach (m_reg[i]) m_reg[i] = 32'h0;
        @(posedge clk); #1;
        tick();
        rst = 0;
        tick();
        chk("reset_rd0", rd[31:0], 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);

        we = 1; wa = 3; wd = 32'hDEADBEEF; wbe = 4'hF; ra0 = 3;
        tick();
        chk("bypass", rd[31:0], 32'hDEADBEEF);
        we = 0;
        tick(); tick();
        chk("reread", rd[31:0], 32'hDEADBEEF);

        we = 1; wa = 5; wd = 32'h11223344; wbe = 4'hF;
        tick();
        wd = 32'hAABBCCDD; wbe = 4'b0101; ra0 = 5;
        tick();
        chk("byte_en", rd[31:0], 32'h11BB33DD);
        wd = 32'h0; wbe = 4'h0;
        tick();
        we = 0;
        tick();
        chk("be_zero", rd[31:0], 32'h11BB33DD);

        pc_in = 32'h100; ra1 = 15;
        tick();
        chk("pc_read", rd[63:32], 32'h108);
        we = 1; wa = 15; wd = 32'h1234; wbe = 4'hF;
        tick();
        chk("pc_wr_drop", rd[63:32], 32'h108);
        we = 0; pc_in = 32'hFFFFFFFC;
        tick();
        chk("pc_wrap", rd[63:32], 32'h4);

        we = 1; wbe = 4'hF;
        for (int i = 0; i < 15; i++) begin
            wa = 4'(i); wd = 32'h01010101 * (i + 1); ra0 = 4'(i);
            tick();
        end
        we = 0; clr_req = 1;
        tick();
        nb = busy ? 1 : 0;
        clr_req = 0;
        for (int k = 0; k < 20; k++) begin
            ra0 = 4'(k); ra1 = 4'(14 - (k % 15));
            we = (k == 3); wa = 2; wd = 32'h5555AAAA;
            clr_req = (k == 6);
            tick();
            if (busy) nb++;
        end
        we = 0; clr_req = 0;
        chk("busy_len", nb, 16);
        for (int i = 0; i < 15; i++) begin
            ra0 = 4'(i);
            tick();
            chk("cleared", rd[31:0], 32'h0);
        end

        we = 1; wa = 9; wd = 32'h99999999; wbe = 4'hF;
        tick();
        we = 0; clr_req = 1;
        tick();
        clr_req = 0;
        tick(); tick(); tick(); tick();
        rst = 1;
        tick();
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        rst = 0; ra0 = 9;
        tick();
        chk("rst_mid_rd", rd[31:0], 32'h0);
        we = 1; wa = 4; wd = 32'hCAFEF00D; ra0 = 4;
        tick();
        chk("post_rst_wr", rd[31:0], 32'hCAFEF00D);
        we = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
